// File: rtl/mem_access.sv
// Memory stage of the RV32I pipeline: registers EX results, runs the data-memory
// handshake, stalls upstream until the response, and aligns/extends load data.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_valid,
  input  logic [6:0]  EX_opcode,
  input  logic [2:0]  EX_funct3,
  input  logic [4:0]  EX_rd,
  input  logic        EX_regfile_load,
  input  logic [31:0] EX_alu_out,
  input  logic [31:0] EX_rs2_data,
  input  logic [31:0] EX_pc,
  input  logic        EX_mispredict,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall_mem,
  output logic        MEM_valid,
  output logic [4:0]  MEM_rd,
  output logic        MEM_regfile_load,
  output logic [31:0] MEM_alu_out,
  output logic [31:0] MEM_pc,
  output logic        MEM_mispredict,
  output logic [31:0] Mem_rdata_load,
  output logic [3:0]  mem_wmask,
  output logic        MEM_misaligned
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        valid_q, valid_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        rl_q, rl_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] pc_q, pc_d;
  logic        mp_q, mp_d;

  // Size comes from funct3[1:0]: byte, half, word.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~a[0];
      default: is_aligned = (a == 2'b00);
    endcase
  endfunction

  logic        ex_is_load, ex_is_store, ex_go;
  logic        st_is_load, st_is_store, misaligned;
  logic [1:0]  a;
  logic [3:0]  wmask_raw;
  logic [31:0] rd_shift, load_ext;

  assign ex_is_load  = EX_valid && (EX_opcode == OpLoad);
  assign ex_is_store = EX_valid && (EX_opcode == OpStore);
  assign ex_go       = (ex_is_load || ex_is_store) && is_aligned(EX_funct3, EX_alu_out[1:0]);

  assign a           = alu_q[1:0];
  assign st_is_load  = valid_q && (opcode_q == OpLoad);
  assign st_is_store = valid_q && (opcode_q == OpStore);
  assign misaligned  = (st_is_load || st_is_store) && !is_aligned(funct3_q, a);

  assign stall_mem   = (state_q == StAccess) && !dmem_resp;

  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    write_d  = write_q;
    valid_d  = valid_q;
    opcode_d = opcode_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    rl_d     = rl_q;
    alu_d    = alu_q;
    rs2_d    = rs2_q;
    pc_d     = pc_q;
    mp_d     = mp_q;
    if (!stall_mem) begin
      state_d  = ex_go ? StAccess : StIdle;
      read_d   = ex_go && ex_is_load;
      write_d  = ex_go && ex_is_store;
      valid_d  = EX_valid;
      opcode_d = EX_opcode;
      funct3_d = EX_funct3;
      rd_d     = EX_rd;
      rl_d     = EX_regfile_load;
      alu_d    = EX_alu_out;
      rs2_d    = EX_rs2_data;
      pc_d     = EX_pc;
      mp_d     = EX_mispredict;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      valid_q  <= 1'b0;
      opcode_q <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      rl_q     <= 1'b0;
      alu_q    <= '0;
      rs2_q    <= '0;
      pc_q     <= '0;
      mp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      write_q  <= write_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      rl_q     <= rl_d;
      alu_q    <= alu_d;
      rs2_q    <= rs2_d;
      pc_q     <= pc_d;
      mp_q     <= mp_d;
    end
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   wmask_raw = 4'b0001 << a;
      2'b01:   wmask_raw = 4'b0011 << a;
      default: wmask_raw = 4'b1111;
    endcase
  end

  assign rd_shift = dmem_rdata >> {a, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'b0, rd_shift[7:0]};
      3'b101:  load_ext = {16'b0, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  assign dmem_read        = read_q;
  assign dmem_write       = write_q;
  assign dmem_address     = {alu_q[31:2], 2'b00};
  assign dmem_wmask       = write_q ? wmask_raw : 4'b0000;
  assign dmem_wdata       = write_q ? (rs2_q << {a, 3'b000}) : 32'b0;
  assign mem_wmask        = dmem_wmask;
  assign Mem_rdata_load   = (read_q && dmem_resp) ? load_ext : 32'b0;

  assign MEM_valid        = valid_q;
  assign MEM_rd           = rd_q;
  assign MEM_regfile_load = rl_q && !misaligned;
  assign MEM_alu_out      = alu_q;
  assign MEM_pc           = pc_q;
  assign MEM_mispredict   = mp_q;
  assign MEM_misaligned   = misaligned;

endmodule

// File: tb/tb_mem_access.sv
// Directed and randomized checks of mem_access against an instruction-level model
// of request timing, byte enables, store shifting and load extension.
module tb_mem_access;

  logic        clk, rst;
  logic        EX_valid, EX_regfile_load, EX_mispredict;
  logic [6:0]  EX_opcode;
  logic [2:0]  EX_funct3;
  logic [4:0]  EX_rd;
  logic [31:0] EX_alu_out, EX_rs2_data, EX_pc;
  logic        dmem_read, dmem_write, dmem_resp, stall_mem;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask, mem_wmask;
  logic        MEM_valid, MEM_regfile_load, MEM_mispredict, MEM_misaligned;
  logic [4:0]  MEM_rd;
  logic [31:0] MEM_alu_out, MEM_pc, Mem_rdata_load;

  mem_access dut (
    .clk(clk), .rst(rst),
    .EX_valid(EX_valid), .EX_opcode(EX_opcode), .EX_funct3(EX_funct3), .EX_rd(EX_rd),
    .EX_regfile_load(EX_regfile_load), .EX_alu_out(EX_alu_out), .EX_rs2_data(EX_rs2_data),
    .EX_pc(EX_pc), .EX_mispredict(EX_mispredict),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall_mem(stall_mem),
    .MEM_valid(MEM_valid), .MEM_rd(MEM_rd), .MEM_regfile_load(MEM_regfile_load),
    .MEM_alu_out(MEM_alu_out), .MEM_pc(MEM_pc), .MEM_mispredict(MEM_mispredict),
    .Mem_rdata_load(Mem_rdata_load), .mem_wmask(mem_wmask), .MEM_misaligned(MEM_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpAlu   = 7'b0110011;

  typedef struct {
    logic        valid;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rl;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic        mp;
    int          n;      // response delay in cycles after the request cycle
    logic [31:0] rdata;
  } instr_t;

  int errors = 0;
  int checks = 0;
  instr_t cur, nop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] rs2,
                                input int n, input logic [31:0] rdata);
    instr_t x;
    x.valid = v; x.op = op; x.f3 = f3; x.rd = 5'd7; x.rl = (op != OpStore);
    x.alu = alu; x.rs2 = rs2; x.pc = alu ^ 32'h5555_0000; x.mp = alu[4];
    x.n = n; x.rdata = rdata;
    return x;
  endfunction

  task automatic present(input instr_t x);
    EX_valid = x.valid; EX_opcode = x.op; EX_funct3 = x.f3; EX_rd = x.rd;
    EX_regfile_load = x.rl; EX_alu_out = x.alu; EX_rs2_data = x.rs2;
    EX_pc = x.pc; EX_mispredict = x.mp;
  endtask

  // Runs the instruction currently in the stage until the edge it leaves on.
  task automatic serve(input instr_t x);
    int unsigned size, a, v, shf;
    logic ld, st, mis, acc;
    logic [31:0] exp_load, exp_wdata;
    logic [3:0]  exp_mask;
    int n;
    ld   = x.valid && x.op == OpLoad;
    st   = x.valid && x.op == OpStore;
    size = (x.f3[1:0] == 2'b00) ? 1 : (x.f3[1:0] == 2'b01) ? 2 : 4;
    a    = x.alu % 4;
    mis  = (ld || st) && (x.alu % size != 0);
    acc  = (ld || st) && !mis;
    shf  = 8 * a;
    v    = x.rdata >> shf;
    case (x.f3)
      3'd0:    exp_load = (v % 256 >= 128) ? (v % 256) + 32'hFFFF_FF00 : v % 256;
      3'd1:    exp_load = (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
      3'd4:    exp_load = v % 256;
      3'd5:    exp_load = v % 65536;
      default: exp_load = v;
    endcase
    exp_mask  = (size == 4) ? 4'hF : 4'((size == 2 ? 3 : 1) << a);
    exp_wdata = x.rs2 << shf;
    n = acc ? x.n : 0;
    for (int k = 0; k <= n; k++) begin
      if (acc) begin
        dmem_resp  = (k == n);
        dmem_rdata = (k == n) ? x.rdata : $urandom;
      end else begin
        dmem_resp  = 1'($urandom_range(0, 1));  // stray responses must be ignored
        dmem_rdata = $urandom;
      end
      #1;
      chk("dmem_read", 32'(dmem_read), 32'(acc && ld));
      chk("dmem_write", 32'(dmem_write), 32'(acc && st));
      chk("stall_mem", 32'(stall_mem), 32'(acc && k != n));
      chk("mem_wmask", 32'(mem_wmask), (acc && st) ? 32'(exp_mask) : 32'd0);
      chk("rdata_load", Mem_rdata_load, (acc && ld && k == n) ? exp_load : 32'd0);
      if (acc) chk("dmem_address", dmem_address, x.alu & 32'hFFFF_FFFC);
      if (acc && st) begin
        chk("dmem_wmask", 32'(dmem_wmask), 32'(exp_mask));
        chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (k == 0) begin
        chk("MEM_valid", 32'(MEM_valid), 32'(x.valid));
        chk("MEM_misaligned", 32'(MEM_misaligned), 32'(mis));
        chk("MEM_regfile_load", 32'(MEM_regfile_load), 32'(x.rl && !mis));
        chk("MEM_alu_out", MEM_alu_out, x.alu);
        chk("MEM_pc", MEM_pc, x.pc);
        chk("MEM_rd", 32'(MEM_rd), 32'(x.rd));
        chk("MEM_mispredict", 32'(MEM_mispredict), 32'(x.mp));
      end
      @(posedge clk); #1;
      dmem_resp = 1'b0;
    end
  endtask

  task automatic step(input instr_t x);
    present(x);
    serve(cur);
    cur = x;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, 32'(dmem_read), 32'd0);
    chk({tag, "_write"}, 32'(dmem_write), 32'd0);
    chk({tag, "_stall"}, 32'(stall_mem), 32'd0);
    chk({tag, "_valid"}, 32'(MEM_valid), 32'd0);
    chk({tag, "_addr"}, dmem_address, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_wmask"}, 32'(dmem_wmask), 32'd0);
    chk({tag, "_mwmask"}, 32'(mem_wmask), 32'd0);
    chk({tag, "_rl"}, 32'(MEM_regfile_load), 32'd0);
    chk({tag, "_pc"}, MEM_pc, 32'd0);
    chk({tag, "_mis"}, 32'(MEM_misaligned), 32'd0);
    chk({tag, "_rdload"}, Mem_rdata_load, 32'd0);
  endtask

  initial begin
    instr_t x;
    logic [31:0] r;
    nop = mk(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 0, 32'd0);
    nop.rl = 1'b0; nop.rd = 5'd0; nop.pc = 32'd0; nop.mp = 1'b0;
    cur = nop;
    present(nop);
    rst = 1'b1; dmem_resp = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    step(mk(1'b1, OpLoad, 3'd2, 32'h0000_1000, 32'd0, 3, 32'hDEAD_BEEF));
    step(mk(1'b1, OpLoad, 3'd0, 32'h0000_1003, 32'd0, 0, 32'h80FF_FFFF));
    step(mk(1'b1, OpLoad, 3'd4, 32'h0000_1003, 32'd0, 0, 32'h80FF_FFFF));
    step(mk(1'b1, OpStore, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 1, 32'd0));
    step(mk(1'b1, OpStore, 3'd2, 32'h0000_2001, 32'h1234_5678, 2, 32'd0));
    step(mk(1'b1, OpLoad, 3'd2, 32'h0000_3000, 32'd0, 1, 32'hCAFE_F00D));
    step(mk(1'b1, OpStore, 3'd2, 32'h0000_3004, 32'h0BAD_CAFE, 1, 32'd0));
    step(mk(1'b0, OpLoad, 3'd2, 32'h0000_4000, 32'd0, 2, 32'd0));
    step(mk(1'b1, OpLoad, 3'd5, 32'h0000_4003, 32'd0, 1, 32'd0));
    step(mk(1'b1, OpAlu, 3'd0, 32'h0000_0042, 32'd0, 0, 32'd0));
    step(nop);
    serve(cur);
    cur = nop;

    // Reset in the second ACCESS cycle of a load, then a late stray response.
    present(mk(1'b1, OpLoad, 3'd2, 32'h0000_5000, 32'd0, 5, 32'h1111_2222));
    @(posedge clk); #1;
    present(nop);
    chk("rst_acc1_read", 32'(dmem_read), 32'd1);
    @(posedge clk); #1;
    chk("rst_acc2_stall", 32'(stall_mem), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("after_rst");
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
    #1;
    chk("stray_stall", 32'(stall_mem), 32'd0);
    chk("stray_rdload", Mem_rdata_load, 32'd0);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk_all_zero("post_stray");
    cur = nop;

    for (int i = 0; i < 300; i++) begin
      int unsigned sel;
      logic [2:0] f3;
      sel = $urandom_range(0, 3);
      r = $urandom;
      case (sel)
        0: begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
          endcase
          x = mk(1'b1, OpLoad, f3, r, 32'd0, int'($urandom_range(0, 3)), $urandom);
        end
        1: x = mk(1'b1, OpStore, 3'($urandom_range(0, 2)), r, $urandom,
                  int'($urandom_range(0, 3)), 32'd0);
        2: x = mk(1'b1, OpAlu, 3'($urandom_range(0, 7)), r, $urandom, 0, 32'd0);
        default: x = mk(1'b0, ($urandom_range(0, 1) == 1) ? OpLoad : OpStore,
                        3'd2, r & 32'hFFFF_FFFC, $urandom, 0, 32'd0);
      endcase
      step(x);
    end
    step(nop);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
